uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller that sequences the UART receiver's recv_req/recv_ack handshake and buffers received characters in a small FIFO. It presents them to the host as a valid/ready stream. It flags overrun when a character arrives with the FIFO full, and raises a receive-timeout pulse when buffered data sits unread through a quiet line period. It sits between the UART receiver and the host/bus interface, sharing the same clock and en_sample tick.

Parameters:
DATA_SIZE, 8, character width; must match the receiver.
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
TIMEOUT_TICKS, 64, en_sample ticks of inactivity before timeout fires (must be >= 2).
LEVEL_SIZE, $clog2(FIFO_DEPTH+1), width of fifo_level.

Ports:
clk  input  1  system clock.
reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
en_sample  input  1  oversample tick shared with the receiver; used only for the timeout counter.
rx_data  input  DATA_SIZE  receiver character output; stable while recv_req=1.
recv_req  input  1  receiver has a complete character.
recv_ack  output  1  registered one-cycle acknowledge to the receiver.
m_data  output  DATA_SIZE  FIFO head character.
m_valid  output  1  FIFO non-empty.
m_ready  input  1  host accepts m_data; pop on m_valid & m_ready.
fifo_level  output  LEVEL_SIZE  current occupancy, 0..FIFO_DEPTH.
overrun  output  1  sticky; a character was dropped.
overrun_clr  input  1  single-cycle clear of overrun.
timeout  output  1  registered one-cycle pulse when the receive timeout expires.

Behaviour:
- Reset values: recv_ack=0, m_valid=0, m_data=0, fifo_level=0, overrun=0, timeout=0, FSM=IDLE, pointers=0, timeout counter=0.
- Handshake FSM with 3 states:
  - IDLE: if recv_req=1, capture rx_data on this edge and go to ACK.
    - Capture rule: if fifo_level < FIFO_DEPTH, push rx_data. Otherwise discard it and set overrun.
    - Fullness is judged on the current level only; a same-cycle pop does not make room.
  - ACK: recv_ack=1 for exactly this cycle; go to WAIT_LOW unconditionally.
  - WAIT_LOW: recv_ack=0; return to IDLE when recv_req=0. Stay while recv_req=1; this guards against a stale request.
  - Minimum spacing between two accepted characters is 3 cycles. Every request is acknowledged, whether pushed or dropped.
- FIFO:
  - Circular buffer with read/write pointers that wrap at FIFO_DEPTH.
  - m_data = mem[rd_ptr], combinational from storage. m_valid = (fifo_level != 0).
  - Push becomes visible on m_valid/m_data the cycle after the capture edge (1-cycle latency).
  - Pop when m_valid & m_ready; m_ready with the FIFO empty is ignored.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - Level never exceeds FIFO_DEPTH and never underflows.
- overrun:
  - Set on a drop.
  - Cleared by overrun_clr; if set and clear occur in the same cycle, set wins.
- Timeout counter (width $clog2(TIMEOUT_TICKS)):
  - Cleared on any push or pop, and held at 0 while fifo_level=0.
  - Otherwise increments on each en_sample.
  - When the counter equals TIMEOUT_TICKS-1 and en_sample=1, assert timeout for 1 cycle and freeze the counter (armed=0).
  - Re-armed only by a push or pop, so there is at most one pulse per idle period.
  - A dropped character does not clear the counter.
- Reset mid-operation (including during ACK or WAIT_LOW): everything returns to reset values immediately. FIFO contents are discarded, and recv_ack drops asynchronously.
- No combinational path from recv_req to recv_ack. m_valid and m_data do not depend on m_ready.

Test Plan:
- Single byte: recv_req=1 with rx_data=0xA5 → recv_ack=1 exactly 1 cycle later for 1 cycle; m_valid=1, m_data=0xA5, fifo_level=1 the cycle after capture. Pop with m_ready=1 → level 0, m_valid=0.
- Fill and overrun (DEPTH=4), m_ready=0: send 0x01..0x05 → level=4; the fifth is still acked; overrun=1. Drain returns 0x01,0x02,0x03,0x04 in order. Pulsing overrun_clr → overrun=0.
- Overrun set/clear collision: drop a character in the same cycle overrun_clr=1 → overrun stays 1.
- Simultaneous push/pop at level=2 → level remains 2; order is preserved across pointer wrap after 10 bytes streamed with m_ready=1.
- Timeout (TIMEOUT_TICKS=64): push 0x3C, hold m_ready=0 → timeout pulses once exactly at the 64th en_sample, with no second pulse after 200 more ticks. A pop then re-arms the counter; the FIFO is empty, so no pulse follows.
- Reset in ACK state: assert reset_n=0 during recv_ack=1 → recv_ack, fifo_level, m_valid, overrun all 0 immediately. After release, the next recv_req is handled normally.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver handshake and host stream bundle for uart_rx_ctrl
interface uart_rx_ctrl_if #(
   parameter int DATA_SIZE = 8
);
   logic [DATA_SIZE-1:0] rx_data;
   logic                 recv_req;
   logic                 recv_ack;
   logic [DATA_SIZE-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;

   // master is the controller; slave is the receiver plus host side
   modport master (
      input  rx_data, recv_req, m_ready,
      output recv_ack, m_data, m_valid
   );

   modport slave (
      output rx_data, recv_req, m_ready,
      input  recv_ack, m_data, m_valid
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive handshake sequencer with character FIFO, overrun and timeout
module uart_rx_ctrl #(
   parameter int DATA_SIZE     = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int TIMEOUT_TICKS = 64,
   parameter int LEVEL_SIZE    = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en_sample,
   uart_rx_ctrl_if.master        bus,
   output logic [LEVEL_SIZE-1:0] fifo_level,
   output logic                  overrun,
   input  logic                  overrun_clr,
   output logic                  timeout
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_TICKS);
   localparam logic [LEVEL_SIZE-1:0] LEVEL_FULL = LEVEL_SIZE'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_WAIT_LOW
   } state_t;

   state_t               state;
   logic                 recv_ack_q;
   logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     idle_cnt;
   logic                 armed;

   logic capture;
   logic fifo_full;
   logic push;
   logic drop;
   logic pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Fullness uses the current level only, so a same-cycle pop never makes room.
   always_comb begin
      capture   = (state == ST_IDLE) && bus.recv_req;
      fifo_full = (fifo_level >= LEVEL_FULL);
      push      = capture && !fifo_full;
      drop      = capture && fifo_full;
      pop       = bus.m_valid && bus.m_ready;
   end

   assign bus.recv_ack = recv_ack_q;
   assign bus.m_valid  = (fifo_level != '0);
   assign bus.m_data   = mem[rd_ptr];

   // WAIT_LOW holds off until the receiver withdraws, so a stale request is never recaptured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         recv_ack_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               recv_ack_q <= 1'b0;
               if (bus.recv_req) begin
                  state      <= ST_ACK;
                  recv_ack_q <= 1'b1;
               end
            end
            ST_ACK: begin
               recv_ack_q <= 1'b0;
               state      <= ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
               recv_ack_q <= 1'b0;
               if (!bus.recv_req) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state      <= ST_IDLE;
               recv_ack_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= bus.rx_data;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

   // One pulse per quiet period: the counter freezes after firing until FIFO traffic re-arms it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
         armed    <= 1'b1;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (push || pop) begin
            idle_cnt <= '0;
            armed    <= 1'b1;
         end else if (fifo_level == '0) begin
            idle_cnt <= '0;
         end else if (armed && en_sample) begin
            if (idle_cnt == CNT_LAST) begin
               timeout <= 1'b1;
               armed   <= 1'b0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
   localparam int DATA_SIZE     = 8;
   localparam int FIFO_DEPTH    = 4;
   localparam int TIMEOUT_TICKS = 64;
   localparam int LEVEL_SIZE    = $clog2(FIFO_DEPTH + 1);

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  en_sample;
   logic                  overrun_clr;
   logic [LEVEL_SIZE-1:0] fifo_level;
   logic                  overrun;
   logic                  timeout;

   logic [DATA_SIZE-1:0]  rx_data_v;
   logic                  req_v;
   logic                  force_ready;
   logic                  rdy_rand;
   int                    ready_mode = 0;
   int                    tick_mode  = 0;

   uart_rx_ctrl_if #(.DATA_SIZE(DATA_SIZE)) bus ();

   assign bus.rx_data  = rx_data_v;
   assign bus.recv_req = req_v;
   assign bus.m_ready  = force_ready | rdy_rand;

   uart_rx_ctrl #(
      .DATA_SIZE    (DATA_SIZE),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .TIMEOUT_TICKS(TIMEOUT_TICKS),
      .LEVEL_SIZE   (LEVEL_SIZE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en_sample  (en_sample),
      .bus        (bus),
      .fifo_level (fifo_level),
      .overrun    (overrun),
      .overrun_clr(overrun_clr),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int to_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      case (ready_mode)
         0:       rdy_rand = 1'b0;
         1:       rdy_rand = 1'b1;
         default: rdy_rand = ($urandom_range(0, 2) == 0);
      endcase
      case (tick_mode)
         0:       en_sample = 1'b0;
         1:       en_sample = 1'b1;
         default: en_sample = ($urandom_range(0, 3) == 0);
      endcase
   end

   // Reference model: expected FIFO contents as a queue plus spec-level flags.
   logic [DATA_SIZE-1:0] exp_q[$];
   int cap_seq  = 0;
   int cap_done = 0;
   bit exp_ack, exp_to, exp_ovr, fired;
   int idle_ticks;

   always @(posedge clk or negedge reset_n) begin
      int sz;
      bit cap, popf, pushf;
      if (!reset_n) begin
         exp_q.delete();
         exp_ack    = 1'b0;
         exp_to     = 1'b0;
         exp_ovr    = 1'b0;
         fired      = 1'b0;
         idle_ticks = 0;
         cap_done   = cap_seq;
      end else begin
         sz       = exp_q.size();
         cap      = (cap_seq != cap_done);
         cap_done = cap_seq;
         popf     = (bus.m_ready === 1'b1) && (sz > 0);
         pushf    = cap && (sz < FIFO_DEPTH);
         exp_ack  = cap;
         if (cap && !pushf) exp_ovr = 1'b1;
         else if (overrun_clr) exp_ovr = 1'b0;
         if (pushf) exp_q.push_back(rx_data_v);
         if (popf) exp_q.delete(0);
         exp_to = 1'b0;
         if (pushf || popf) begin
            idle_ticks = 0;
            fired      = 1'b0;
         end else if (sz == 0) begin
            idle_ticks = 0;
         end else if (en_sample && !fired) begin
            idle_ticks++;
            if (idle_ticks == TIMEOUT_TICKS) begin
               exp_to = 1'b1;
               fired  = 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         check("recv_ack", 32'(bus.recv_ack), 32'(exp_ack));
         check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
         check("m_valid", 32'(bus.m_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
         check("overrun", 32'(overrun), 32'(exp_ovr));
         check("timeout", 32'(timeout), 32'(exp_to));
         if (timeout === 1'b1) to_pulses++;
      end
   end

   task automatic send_char(input logic [DATA_SIZE-1:0] d, input int hold,
                            input bit with_clr, input bit with_pop);
      @(negedge clk);
      rx_data_v = d;
      req_v     = 1'b1;
      cap_seq++;
      if (with_clr) overrun_clr = 1'b1;
      if (with_pop) force_ready = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      force_ready = 1'b0;
      repeat (hold) @(negedge clk);
      req_v     = 1'b0;
      rx_data_v = DATA_SIZE'($urandom);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      @(negedge clk);
      force_ready = 1'b1;
      while (fifo_level != '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      force_ready = 1'b0;
      check(name, 32'(fifo_level), 32'd0);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
   endtask

   initial begin
      int p0;
      reset_n     = 1'b0;
      req_v       = 1'b0;
      rx_data_v   = '0;
      overrun_clr = 1'b0;
      force_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_recv_ack", 32'(bus.recv_ack), 32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_data", 32'(bus.m_data), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      reset_n = 1'b1;

      send_char(8'hA5, 0, 1'b0, 1'b0);
      check("single_level", 32'(fifo_level), 32'd1);
      check("single_data", 32'(bus.m_data), 32'hA5);
      force_ready = 1'b1;
      @(negedge clk);
      force_ready = 1'b0;
      check("single_pop_level", 32'(fifo_level), 32'd0);
      check("single_pop_valid", 32'(bus.m_valid), 32'd0);

      for (int i = 1; i <= 5; i++) send_char(DATA_SIZE'(i), 0, 1'b0, 1'b0);
      check("fill_level", 32'(fifo_level), 32'd4);
      check("fill_overrun", 32'(overrun), 32'd1);
      wait_empty("fill_drain");
      pulse_clr();
      check("overrun_cleared", 32'(overrun), 32'd0);

      for (int i = 0; i < 5; i++) send_char(DATA_SIZE'($urandom), 0, 1'b0, 1'b0);
      send_char(8'h77, 1, 1'b1, 1'b0);
      check("overrun_collision", 32'(overrun), 32'd1);
      wait_empty("collision_drain");
      pulse_clr();

      send_char(8'h11, 0, 1'b0, 1'b0);
      send_char(8'h22, 0, 1'b0, 1'b0);
      send_char(8'h33, 0, 1'b0, 1'b1);
      check("push_pop_level", 32'(fifo_level), 32'd2);
      wait_empty("push_pop_drain");
      ready_mode = 1;
      for (int i = 0; i < 10; i++) send_char(DATA_SIZE'($urandom), 0, 1'b0, 1'b0);
      ready_mode = 0;
      wait_empty("stream_drain");

      tick_mode = 1;
      p0 = to_pulses;
      send_char(8'h3C, 0, 1'b0, 1'b0);
      repeat (TIMEOUT_TICKS + 200) @(negedge clk);
      check("timeout_once", 32'(to_pulses - p0), 32'd1);
      force_ready = 1'b1;
      @(negedge clk);
      force_ready = 1'b0;
      repeat (100) @(negedge clk);
      check("timeout_rearm_empty", 32'(to_pulses - p0), 32'd1);
      tick_mode = 0;

      for (int i = 0; i < 5; i++) send_char(DATA_SIZE'($urandom), 0, 1'b0, 1'b0);
      @(negedge clk);
      rx_data_v = 8'hEE;
      req_v     = 1'b1;
      cap_seq++;
      @(negedge clk);
      check("ack_before_reset", 32'(bus.recv_ack), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_ack_recv_ack", 32'(bus.recv_ack), 32'd0);
      check("rst_ack_level", 32'(fifo_level), 32'd0);
      check("rst_ack_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_ack_overrun", 32'(overrun), 32'd0);
      check("rst_ack_m_data", 32'(bus.m_data), 32'd0);
      req_v = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      send_char(8'h5A, 0, 1'b0, 1'b0);
      check("post_reset_level", 32'(fifo_level), 32'd1);
      check("post_reset_data", 32'(bus.m_data), 32'h5A);
      wait_empty("post_reset_drain");

      ready_mode = 2;
      tick_mode  = 2;
      for (int i = 0; i < 60; i++) begin
         send_char(DATA_SIZE'($urandom), $urandom_range(0, 2),
                   ($urandom_range(0, 5) == 0), 1'b0);
      end
      ready_mode = 0;
      tick_mode  = 0;
      wait_empty("random_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
